// File: rtl/home_inventory_wb_host.sv
// Single-outstanding Wishbone classic initiator: one valid/ready command becomes
// one bus cycle, answered by one response carrying read data or a timeout flag.
module home_inventory_wb_host #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_we,
   input  logic [31:0] cmd_adr,
   input  logic [31:0] cmd_dat,
   input  logic [3:0]  cmd_sel,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic        wbm_ack_i,
   input  logic [31:0] wbm_dat_i
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   // Counter value at the edge that closes the last permitted STB cycle.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t     state;
   logic [7:0] tmo_cnt;

   assign cmd_ready = (state == IDLE);

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state     <= IDLE;
         tmo_cnt   <= 8'd0;
         rsp_valid <= 1'b0;
         rsp_dat   <= 32'd0;
         rsp_err   <= 1'b0;
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= 4'd0;
         wbm_adr_o <= 32'd0;
         wbm_dat_o <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  wbm_cyc_o <= 1'b1;
                  wbm_stb_o <= 1'b1;
                  wbm_we_o  <= cmd_we;
                  wbm_sel_o <= cmd_sel;
                  wbm_adr_o <= cmd_adr;
                  wbm_dat_o <= cmd_dat;
                  tmo_cnt   <= 8'd0;
                  state     <= BUS;
               end
            end
            BUS: begin
               // Ack takes priority over a timeout landing on the same edge.
               if (wbm_ack_i || (tmo_cnt == TMO_LAST)) begin
                  wbm_cyc_o <= 1'b0;
                  wbm_stb_o <= 1'b0;
                  wbm_we_o  <= 1'b0;
                  wbm_sel_o <= 4'd0;
                  wbm_adr_o <= 32'd0;
                  wbm_dat_o <= 32'd0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= !wbm_ack_i;
                  rsp_dat   <= (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : ERR_DATA;
                  state     <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_home_inventory_wb_host.sv
// Directed bench for home_inventory_wb_host with a small register-map slave
// (ID, VERSION, CTRL, STATUS, TARE_CH0) that has programmable ack latency.
module tb_home_inventory_wb_host;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
   logic [31:0] cmd_adr = '0, cmd_dat = '0;
   logic [3:0]  cmd_sel = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
   logic [31:0] rsp_dat;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, wdat, rdat_bus;
   logic        ack;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   home_inventory_wb_host #(.TIMEOUT_CYCLES(16), .ERR_DATA(32'h0000_0000)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
      .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
      .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_ack_i(ack), .wbm_dat_i(rdat_bus)
   );

   // Stub slave: acks in STB cycle s_lat when enabled; force_ack injects stray acks.
   logic        s_en = 1'b1;
   logic [7:0]  s_lat = 8'd1;
   logic        force_ack = 1'b0;
   logic [7:0]  s_cnt = 8'd0;
   logic [1:0]  ctrl = 2'd0;
   logic [31:0] tare = 32'd0;
   logic [7:0]  core_status = 8'd0;

   assign ack = (cyc && stb && s_en && (s_cnt == s_lat - 8'd1)) || force_ack;

   always @(posedge clk) begin
      if (!(cyc && stb) || ack) s_cnt <= 8'd0;
      else                      s_cnt <= s_cnt + 8'd1;
      if (cyc && stb && ack && we) begin
         if (adr == 32'h8) ctrl <= wdat[1:0];
         if (adr == 32'h300) begin
            for (int b = 0; b < 4; b++)
               if (sel[b]) tare[b*8 +: 8] <= wdat[b*8 +: 8];
         end
      end
   end

   always_comb begin
      rdat_bus = 32'hCAFE_0000 | {16'h0, adr[15:0]};
      case (adr)
         32'h0:   rdat_bus = 32'h4849_4348;
         32'h4:   rdat_bus = 32'h0000_0001;
         32'h8:   rdat_bus = {30'd0, ctrl};
         32'h108: rdat_bus = {24'd0, core_status};
         32'h300: rdat_bus = tare;
         default: ;
      endcase
      if (we) rdat_bus = 32'hFFFF_FFFF;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Issue one command, count STB cycles until the response, optionally consume it.
   task automatic txn(input logic t_we, input logic [31:0] t_adr, input logic [31:0] t_dat,
                      input logic [3:0] t_sel, input bit release_rsp,
                      output logic [31:0] r_dat, output logic r_err, output int stbs);
      bit first;
      @(negedge clk);
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_we = t_we; cmd_adr = t_adr; cmd_dat = t_dat; cmd_sel = t_sel; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      stbs = 0;
      first = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (rsp_valid) break;
         if (stb) begin
            if (first) begin
               chk("bus_adr", adr, t_adr);
               chk("bus_sel", sel, t_sel);
               chk("bus_we", we, t_we);
               chk("bus_cyc", cyc, 1);
               if (t_we) chk("bus_dat", wdat, t_dat);
               first = 1'b0;
            end
            stbs++;
         end
      end
      chk("rsp_seen", rsp_valid, 1);
      chk("cyc_after_ack", cyc, 0);
      chk("adr_cleared", adr, 32'd0);
      r_dat = rsp_dat;
      r_err = rsp_err;
      if (release_rsp) begin
         rsp_ready = 1'b1;
         @(posedge clk);
         #1 rsp_ready = 1'b0;
         @(negedge clk);
         chk("rsp_dropped", rsp_valid, 0);
         chk("cmd_ready_after", cmd_ready, 1);
      end
   endtask

   logic [31:0] r_dat;
   logic        r_err;
   int          stbs;
   int          seen;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_dat", rsp_dat, 0);
      chk("rst_cyc_stb_we", {cyc, stb, we}, 0);
      chk("rst_sel", sel, 0);
      chk("rst_adr", adr, 0);
      chk("rst_dat", wdat, 0);
      rst_n = 1'b1;

      // Minimum latency: one STB cycle, response right after.
      s_lat = 8'd1;
      txn(1'b0, 32'h0, 32'h0, 4'hF, 1'b1, r_dat, r_err, stbs);
      chk("id_fast_stbs", stbs, 1);
      chk("id_fast_dat", r_dat, 32'h4849_4348);

      s_lat = 8'd3;
      txn(1'b0, 32'h0, 32'h0, 4'hF, 1'b1, r_dat, r_err, stbs);
      chk("id_stbs", stbs, 3);
      chk("id_dat", r_dat, 32'h4849_4348);
      chk("id_err", r_err, 0);

      // CTRL write then readback.
      s_lat = 8'd2;
      txn(1'b1, 32'h8, 32'h1, 4'hF, 1'b1, r_dat, r_err, stbs);
      chk("wr_ctrl_dat", r_dat, 32'h0);
      chk("wr_ctrl_err", r_err, 0);
      chk("ctrl_enable", ctrl[0], 1);
      txn(1'b0, 32'h8, 32'h0, 4'hF, 1'b1, r_dat, r_err, stbs);
      chk("rd_ctrl", r_dat, 32'h1);

      // Byte-strobe merge into TARE_CH0.
      txn(1'b1, 32'h300, 32'h0000_BEEF, 4'b0011, 1'b1, r_dat, r_err, stbs);
      txn(1'b1, 32'h300, 32'hDEAD_0000, 4'b1100, 1'b1, r_dat, r_err, stbs);
      txn(1'b0, 32'h300, 32'h0, 4'hF, 1'b1, r_dat, r_err, stbs);
      chk("tare_merge", r_dat, 32'hDEAD_BEEF);

      // Timeout, then ack landing on the timeout edge.
      s_en = 1'b0;
      txn(1'b0, 32'h1234, 32'h0, 4'hF, 1'b1, r_dat, r_err, stbs);
      chk("tmo_stbs", stbs, 16);
      chk("tmo_err", r_err, 1);
      chk("tmo_dat", r_dat, 32'h0);
      s_en = 1'b1;
      s_lat = 8'd16;
      txn(1'b0, 32'h1234, 32'h0, 4'hF, 1'b1, r_dat, r_err, stbs);
      chk("late_ack_stbs", stbs, 16);
      chk("late_ack_err", r_err, 0);
      chk("late_ack_dat", r_dat, 32'hCAFE_1234);

      // Backpressure on VERSION read.
      s_lat = 8'd2;
      txn(1'b0, 32'h4, 32'h0, 4'hF, 1'b0, r_dat, r_err, stbs);
      chk("ver_dat", r_dat, 32'h1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_valid", rsp_valid, 1);
         chk("bp_dat", rsp_dat, 32'h1);
         chk("bp_cmd_ready", cmd_ready, 0);
         chk("bp_cyc", cyc, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      chk("bp_not_ready_yet", cmd_ready, 1);
      @(negedge clk);
      chk("bp_release_ready", cmd_ready, 1);
      chk("bp_release_valid", rsp_valid, 0);

      // Stray ack while idle is ignored.
      @(negedge clk);
      force_ack = 1'b1;
      @(posedge clk);
      #1 force_ack = 1'b0;
      @(negedge clk);
      chk("stray_ack_valid", rsp_valid, 0);
      chk("stray_ack_ready", cmd_ready, 1);

      // Async reset in the 3rd STB cycle of a stalled read.
      s_en = 1'b0;
      @(negedge clk);
      cmd_we = 1'b0; cmd_adr = 32'h1234; cmd_sel = 4'hF; cmd_valid = 1'b1;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && seen < 3; i++) begin
         @(negedge clk);
         if (stb) seen++;
      end
      chk("stall_stb3", seen, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("async_cyc", cyc, 0);
      chk("async_stb", stb, 0);
      repeat (2) @(negedge clk);
      chk("rst_no_rsp", rsp_valid, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", cmd_ready, 1);
      chk("post_rst_valid", rsp_valid, 0);
      s_en = 1'b1;
      core_status = 8'hA5;
      txn(1'b0, 32'h108, 32'h0, 4'hF, 1'b1, r_dat, r_err, stbs);
      chk("status_a5", r_dat[7:0], 8'hA5);
      chk("status_err", r_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/home_inventory_wb_host.md
Name: home_inventory_wb_host

Overview:
Single-outstanding Wishbone classic initiator. Converts a valid/ready command stream (address, data, byte select, direction) into one Wishbone cycle and returns a response with a timeout/error flag. Sits between the bring-up sequencer / test harness logic and the home_inventory_wb register block, as the bus-driving end of that interface. It is used to exercise the register map (ID, CTRL, IRQ_EN, ADC, calibration, event counters) from on-chip logic.

Parameters:
TIMEOUT_CYCLES, 16, max bus cycles with STB high before the transaction is aborted with error; legal range 2..255
ERR_DATA, 32'h0000_0000, rsp_dat value returned on timeout and on all writes

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept a command (high only in IDLE)
cmd_we  in  1  1=write, 0=read
cmd_adr  in  32  byte address
cmd_dat  in  32  write data
cmd_sel  in  4  byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_dat  out  32  read data (ERR_DATA for writes/timeout)
rsp_err  out  1  1=transaction timed out
wbm_cyc_o  out  1  Wishbone CYC
wbm_stb_o  out  1  Wishbone STB
wbm_we_o  out  1  Wishbone WE
wbm_sel_o  out  4  Wishbone SEL
wbm_adr_o  out  32  Wishbone ADR
wbm_dat_o  out  32  Wishbone write data
wbm_ack_i  in  1  Wishbone ACK
wbm_dat_i  in  32  Wishbone read data

Behaviour:
- One clock domain, wb_clk_i. Reset is asynchronous and active-low on wb_rst_ni; all state is cleared immediately on assertion, with synchronous release.
- Reset values: state=IDLE, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_dat=0, and every wbm_* output=0. The timeout counter is 0.
- All wbm_* outputs, rsp_valid, rsp_dat and rsp_err are registered. cmd_ready is combinational and equals (state==IDLE).
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - On cmd_valid && cmd_ready at edge N, latch the command onto wbm_adr/dat/sel/we.
  - Set cyc=stb=1 and enter BUS, so the bus is active from cycle N+1.
  - The timeout counter is cleared.
- BUS:
  - wbm_* outputs are held stable.
  - The counter increments at each edge where ack is low.
  - At the edge where wbm_ack_i=1:
    - Drop cyc/stb/we and zero sel/adr/dat.
    - rsp_dat = wbm_dat_i for reads, ERR_DATA for writes.
    - rsp_err=0, rsp_valid=1, enter RESP.
  - Timeout: at the edge where the counter equals TIMEOUT_CYCLES-1 and ack is low:
    - Drop the bus the same way.
    - rsp_err=1, rsp_dat=ERR_DATA, rsp_valid=1, enter RESP.
    - Result: STB is high for exactly TIMEOUT_CYCLES cycles.
  - Ack in the same cycle as the timeout condition: ack wins, so rsp_err=0.
- RESP:
  - The bus is idle (cyc=0), guaranteeing at least one idle cycle between transactions.
  - rsp_valid, rsp_dat and rsp_err are held until rsp_valid && rsp_ready at an edge.
  - Then: rsp_valid=0, return to IDLE, cmd_ready=1 in the following cycle.
  - Commands are never accepted while a response is pending; there is no skid or buffering.
- wbm_ack_i outside BUS is ignored: no state change and no response.
- cmd_sel=0 is legal and is passed through unchanged. Address is passed through unmodified, with no alignment checking.
- Minimum latency with a slave that acks in the first STB cycle:
  - Accept at N, STB at N+1.
  - rsp_valid at N+2.
  - Next accept at N+3 if rsp_ready is held high.
- Reset mid-BUS: cyc/stb drop asynchronously and no response is generated. After release the block is in IDLE.

Test Plan:
- Read ID against home_inventory_wb (address 0x0, sel=F):
  - rsp_valid with rsp_dat=0x4849_4348 and rsp_err=0.
  - STB high for exactly the slave's ack latency; cyc=0 in the cycle after ack.
- Write CTRL=0x1 then read CTRL:
  - Write response has rsp_dat=0 and err=0; slave ctrl_enable=1.
  - Read returns bit0=1, bit1=0.
- Byte-strobe pair to TARE_CH0 (0x300): 0x0000_BEEF with sel=0011, then 0xDEAD_0000 with sel=1100; a following read returns 0xDEAD_BEEF.
- Timeout: stub slave with ack tied low, TIMEOUT_CYCLES=16, read 0x1234:
  - STB high for exactly 16 cycles, then rsp_valid=1, rsp_err=1, rsp_dat=0.
  - A repeat where ack arrives in the 16th STB cycle gives rsp_err=0 and the slave data.
- Backpressure: hold rsp_ready=0 for 10 cycles after a read of VERSION (0x4):
  - rsp_valid and rsp_dat=0x1 are held stable; cmd_ready=0 throughout; cyc=0 throughout.
  - Release gives cmd_ready=1 one cycle after the handshake.
- Async reset: pull wb_rst_ni low in the 3rd STB cycle of a stalled transaction:
  - cyc/stb drop without waiting for a clock edge; no rsp_valid.
  - After release, a read of STATUS (0x108) with core_status=0xA5 returns 0xA5 in bits [7:0].
